// File: rtl/backup_sched.sv
// rtl/backup_sched.sv - backup scheduler: arms dirty trackers, copies snapshot-pending registers to NVM
//
// Walks the register file once per backup request. It pulses Backup_en to
// arm every tracker, then scans the registers in index order. Each register
// selected for backup is written to NVM over a valid/ready port. Registers
// that were snapshot-pending (code 10/11) then get a one-hot Backup_ack.
//
// Build option: BACKUP_SELECTIVE_EN
//   defined   - only snapshot-pending registers are written to NVM
//   undefined - every register is written; acks still go only to
//               snapshot-pending registers
//
// Ports:
//   Clk, Rst      rising-edge clock, synchronous active-high reset
//   Backup_req    backup request level, sampled only in IDLE
//   Dirty_vals    tracker codes, register i at [2i+1:2i]
//                 (00 CLEAN, 01 DIRTY, 10 READ, 11 DIRTY_WR)
//   Backup_en     one-cycle broadcast arm pulse
//   Backup_ack    one-hot, one-cycle completion pulse per register
//   Rd_idx        register file read index (driven from idx)
//   Rd_data       register file read data for Rd_idx
//   Nvm_wr_valid  NVM write request
//   Nvm_wr_ready  NVM write accept
//   Nvm_addr      NVM slot (register index)
//   Nvm_data      NVM write data
//   Busy          high outside IDLE
//   Backup_done   one-cycle pulse at the end of a pass
module backup_sched #(
  parameter int NREGS = 8,
  parameter int WIDTH = 32,
  parameter int IDXW  = 3
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Backup_req,
  input  logic [2*NREGS-1:0] Dirty_vals,
  output logic               Backup_en,
  output logic [NREGS-1:0]   Backup_ack,
  output logic [IDXW-1:0]    Rd_idx,
  input  logic [WIDTH-1:0]   Rd_data,
  output logic               Nvm_wr_valid,
  input  logic               Nvm_wr_ready,
  output logic [IDXW-1:0]    Nvm_addr,
  output logic [WIDTH-1:0]   Nvm_data,
  output logic               Busy,
  output logic               Backup_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_SCAN  = 3'd2,
    S_WRITE = 3'd3,
    S_ACK   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDXW-1:0]    r_idx;
  logic               r_elig;
  logic [IDXW-1:0]    r_nvm_addr;
  logic [WIDTH-1:0]   r_nvm_data;
  logic               r_backup_en;
  logic [NREGS-1:0]   r_backup_ack;
  logic               r_nvm_wr_valid;
  logic               r_busy;
  logic               r_backup_done;

  logic [1:0]         w_code;
  logic               w_elig;
  logic               w_last;
  logic               w_en_nxt;
  logic [NREGS-1:0]   w_ack_nxt;
  logic               w_valid_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  assign w_code = Dirty_vals[{r_idx, 1'b0} +: 2];
  assign w_elig = (w_code == 2'b10) || (w_code == 2'b11);
  assign w_last = (r_idx == IDXW'(NREGS - 1));

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Backup_req) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        w_state_nxt = S_SCAN;
      end
      S_SCAN: begin
`ifdef BACKUP_SELECTIVE_EN
        if (w_elig) begin
          w_state_nxt = S_WRITE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
`else
        w_state_nxt = S_WRITE;
`endif
      end
      S_WRITE: begin
        if (Nvm_wr_ready) begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        w_state_nxt = w_last ? S_DONE : S_SCAN;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode works on the next state, so that registered outputs
  // line up with the state they belong to.
  always_comb begin
    w_en_nxt    = (w_state_nxt == S_ARM);
    w_valid_nxt = (w_state_nxt == S_WRITE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    w_done_nxt  = (w_state_nxt == S_DONE);
    w_ack_nxt   = '0;
    if ((w_state_nxt == S_ACK) && r_elig) begin
      w_ack_nxt = NREGS'(1) << r_nvm_addr;
    end
  end

  // Index counter and write capture. The eligibility seen in SCAN is held
  // so a 10 -> 11 move during the WRITE stall still earns its ack.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_idx      <= '0;
      r_elig     <= 1'b0;
      r_nvm_addr <= '0;
      r_nvm_data <= '0;
    end else begin
      case (r_state)
        S_ARM: begin
          r_idx <= '0;
        end
        S_SCAN: begin
          if (w_state_nxt == S_WRITE) begin
            r_nvm_addr <= r_idx;
            r_nvm_data <= Rd_data;
            r_elig     <= w_elig;
          end else if (!w_last) begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        S_ACK: begin
          if (!w_last) begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_backup_en    <= 1'b0;
      r_backup_ack   <= '0;
      r_nvm_wr_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_backup_done  <= 1'b0;
    end else begin
      r_backup_en    <= w_en_nxt;
      r_backup_ack   <= w_ack_nxt;
      r_nvm_wr_valid <= w_valid_nxt;
      r_busy         <= w_busy_nxt;
      r_backup_done  <= w_done_nxt;
    end
  end

  assign Backup_en    = r_backup_en;
  assign Backup_ack   = r_backup_ack;
  assign Nvm_wr_valid = r_nvm_wr_valid;
  assign Busy         = r_busy;
  assign Backup_done  = r_backup_done;
  assign Nvm_addr     = r_nvm_addr;
  assign Nvm_data     = r_nvm_data;
  assign Rd_idx       = r_idx;

endmodule

// File: tb/tb_backup_sched.sv
// tb/tb_backup_sched.sv - directed self-checking bench for backup_sched
module tb_backup_sched;

  localparam int N = 8;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Backup_req;
  logic [15:0] trk;
  logic        Backup_en;
  logic [7:0]  Backup_ack;
  logic [2:0]  Rd_idx;
  logic [31:0] Rd_data;
  logic        Nvm_wr_valid;
  logic        Nvm_wr_ready;
  logic [2:0]  Nvm_addr;
  logic [31:0] Nvm_data;
  logic        Busy;
  logic        Backup_done;

  logic [31:0] rf [N];

  backup_sched #(.NREGS(8), .WIDTH(32), .IDXW(3)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Backup_req   (Backup_req),
    .Dirty_vals   (trk),
    .Backup_en    (Backup_en),
    .Backup_ack   (Backup_ack),
    .Rd_idx       (Rd_idx),
    .Rd_data      (Rd_data),
    .Nvm_wr_valid (Nvm_wr_valid),
    .Nvm_wr_ready (Nvm_wr_ready),
    .Nvm_addr     (Nvm_addr),
    .Nvm_data     (Nvm_data),
    .Busy         (Busy),
    .Backup_done  (Backup_done)
  );

  assign Rd_data = rf[Rd_idx];

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  // monitor state
  logic [2:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  logic [7:0]  acks    [$];
  int          en_cnt;
  int          done_cnt;
  // stall targets: address, stall length, expected held data
  logic [2:0]  sq_a [$];
  int          sq_n [$];
  logic [31:0] sq_d [$];
  logic [2:0]  stall_addr;
  int          stall_left;
  logic [31:0] stall_data;
  logic        stalling;
  int          stall_seen;
  logic        race_en;
  logic        inject6;
  // expectations
  int          exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [7:0]  exp_ack [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    acks.delete();
    sq_a.delete();
    sq_n.delete();
    sq_d.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_ack.delete();
    en_cnt     = 0;
    done_cnt   = 0;
    stall_left = 0;
    stalling   = 1'b0;
    stall_seen = 0;
    stall_addr = '0;
    stall_data = '0;
  endtask

  task automatic init_rf();
    for (int i = 0; i < N; i++) rf[i] = 32'hDA7A_0000 + i;
  endtask

  // One clock: sample at the falling edge, model trackers and NVM ready.
  task automatic tick();
    @(negedge Clk);
    if (Backup_en) begin
      en_cnt++;
      for (int i = 0; i < N; i++)
        if (trk[2*i +: 2] == 2'b01) trk[2*i +: 2] = 2'b10;
      if (inject6) trk[13:12] = 2'b01;
    end
    for (int i = 0; i < N; i++)
      if (Backup_ack[i]) trk[2*i +: 2] = 2'b00;
    if (|Backup_ack) acks.push_back(Backup_ack);
    if (Backup_done) done_cnt++;
    if (stall_left == 0) begin
      stalling = 1'b0;
      if (sq_a.size() > 0) begin
        stall_addr = sq_a.pop_front();
        stall_left = sq_n.pop_front();
        stall_data = sq_d.pop_front();
      end
    end
    if (stall_left > 0 && Nvm_wr_valid && (stalling || Nvm_addr == stall_addr)) begin
      stalling     = 1'b1;
      Nvm_wr_ready = 1'b0;
      stall_left--;
      stall_seen++;
      chk("stall_addr", {29'd0, Nvm_addr}, {29'd0, stall_addr});
      chk("stall_data", Nvm_data, stall_data);
      if (race_en && stall_addr == 3'd1) begin
        trk[3:2] = 2'b11;
        rf[1]    = 32'hBAD0_0001;
      end
    end else begin
      Nvm_wr_ready = 1'b1;
    end
    if (Nvm_wr_valid && Nvm_wr_ready) begin
      wr_addr.push_back(Nvm_addr);
      wr_data.push_back(Nvm_data);
    end
  endtask

  // Pulse Backup_req; cycle 1 is the cycle after the sampling edge.
  task automatic run_pass(output int en_cyc, output int done_cyc);
    int n;
    en_cyc   = -1;
    done_cyc = -1;
    n        = 0;
    Backup_req = 1'b1;
    while (done_cyc < 0 && n < 100) begin
      tick();
      n++;
      Backup_req = 1'b0;
      if (Backup_en && en_cyc < 0) en_cyc = n;
      if (Backup_done) done_cyc = n;
    end
    chk("pass_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    tick();
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), exp_wa.size());
    for (int k = 0; k < exp_wa.size(); k++) begin
      chk({tag, "_addr"}, (k < wr_addr.size()) ? {29'd0, wr_addr[k]} : 32'hFFFF_FFFF, exp_wa[k]);
      chk({tag, "_data"}, (k < wr_data.size()) ? wr_data[k] : 32'hFFFF_FFFF, exp_wd[k]);
    end
    chk({tag, "_nack"}, acks.size(), exp_ack.size());
    for (int k = 0; k < exp_ack.size(); k++)
      chk({tag, "_ack"}, (k < acks.size()) ? {24'd0, acks[k]} : 32'hFFFF_FFFF, {24'd0, exp_ack[k]});
  endtask

  int en_c, done_c, n, e1, e2, d1, d2;
  int t2_done, t3_done, t5_d1, t5_p2, t6_done;

  initial begin
`ifdef BACKUP_SELECTIVE_EN
    t2_done = 14; t3_done = 20; t5_d1 = 12; t5_p2 = 9;  t6_done = 10;
`else
    t2_done = 26; t3_done = 32; t5_d1 = 26; t5_p2 = 25; t6_done = 26;
`endif
    Rst          = 1'b1;
    Backup_req   = 1'b0;
    trk          = 16'h0000;
    Nvm_wr_ready = 1'b1;
    race_en      = 1'b0;
    inject6      = 1'b0;
    init_rf();
    clear_mon();

    // Reset: two cycles, all outputs low
    tick();
    tick();
    chk("rst_en",    {31'd0, Backup_en}, 32'd0);
    chk("rst_ack",   {24'd0, Backup_ack}, 32'd0);
    chk("rst_valid", {31'd0, Nvm_wr_valid}, 32'd0);
    chk("rst_busy",  {31'd0, Busy}, 32'd0);
    chk("rst_done",  {31'd0, Backup_done}, 32'd0);
    chk("rst_addr",  {29'd0, Nvm_addr}, 32'd0);
    chk("rst_data",  Nvm_data, 32'd0);
    chk("rst_rdidx", {29'd0, Rd_idx}, 32'd0);
    Rst = 1'b0;
    tick();

    // Pass A: regs 2 and 5 dirty, ready high
    clear_mon();
    trk = 16'h0000;
    trk[5:4]   = 2'b01;
    trk[11:10] = 2'b01;
`ifdef BACKUP_SELECTIVE_EN
    exp_wa = '{2, 5};
`else
    exp_wa = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    foreach (exp_wa[k]) exp_wd.push_back(32'hDA7A_0000 + exp_wa[k]);
    exp_ack = '{8'h04, 8'h20};
    run_pass(en_c, done_c);
    chk("a_en_cyc", en_c, 32'd1);
    chk("a_done_cyc", done_c, t2_done);
    check_writes("a");
    chk("a_trk_after", {16'd0, trk}, 32'h0000_0000);
    chk("a_busy_idle", {31'd0, Busy}, 32'd0);

    // Pass B: stall on reg 1 (race to 11) and reg 3, reg 6 written after arm
    clear_mon();
    init_rf();
    trk = 16'h0000;
    trk[3:2] = 2'b01;
    trk[7:6] = 2'b01;
    race_en = 1'b1;
    inject6 = 1'b1;
    sq_a = '{3'd1, 3'd3};
    sq_n = '{2, 4};
    sq_d = '{32'hDA7A_0001, 32'hDA7A_0003};
`ifdef BACKUP_SELECTIVE_EN
    exp_wa = '{1, 3};
`else
    exp_wa = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    foreach (exp_wa[k]) exp_wd.push_back(32'hDA7A_0000 + exp_wa[k]);
    exp_ack = '{8'h02, 8'h08};
    run_pass(en_c, done_c);
    race_en = 1'b0;
    inject6 = 1'b0;
    chk("b_done_cyc", done_c, t3_done);
    chk("b_stall_cycles", stall_seen, 32'd6);
    check_writes("b");
    chk("b_trk_after", {16'd0, trk}, 32'h0000_1000);

    // Abort: reset during the write of reg 4
    clear_mon();
    init_rf();
    trk = 16'h0000;
    trk[9:8] = 2'b01;
    sq_a = '{3'd4};
    sq_n = '{50};
    sq_d = '{32'hDA7A_0004};
    Backup_req = 1'b1;
    n = 0;
    tick();
    Backup_req = 1'b0;
    while (!(Nvm_wr_valid && Nvm_addr == 3'd4) && n < 60) begin
      tick();
      n++;
    end
    chk("abort_write_seen", {31'd0, Nvm_wr_valid}, 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    stall_left = 0;
    stalling   = 1'b0;
    chk("abort_busy",  {31'd0, Busy}, 32'd0);
    chk("abort_valid", {31'd0, Nvm_wr_valid}, 32'd0);
    chk("abort_rdidx", {29'd0, Rd_idx}, 32'd0);
    repeat (5) tick();
    chk("abort_nack",  acks.size(), 32'd0);
    chk("abort_ndone", done_cnt, 32'd0);
    chk("abort_trk",   {16'd0, trk}, 32'h0000_0200);

    // Retrigger: request held through the first pass
    clear_mon();
    e1 = -1; e2 = -1; d1 = -1; d2 = -1;
    n = 0;
    Backup_req = 1'b1;
    while (d2 < 0 && n < 200) begin
      tick();
      n++;
      if (Backup_en) begin
        if (e1 < 0) e1 = n;
        else if (e2 < 0) begin
          e2 = n;
          Backup_req = 1'b0;
        end
      end
      if (Backup_done) begin
        if (d1 < 0) d1 = n;
        else d2 = n;
      end
    end
    Backup_req = 1'b0;
    repeat (4) tick();
    chk("retrig_e1", e1, 32'd1);
    chk("retrig_d1", d1, t5_d1);
    chk("retrig_gap", e2 - d1, 32'd2);
    chk("retrig_p2", d2 - e2, t5_p2);
    chk("retrig_nen", en_cnt, 32'd2);
    chk("retrig_ndone", done_cnt, 32'd2);
    chk("retrig_nack", acks.size(), 32'd1);
    chk("retrig_ack", (acks.size() > 0) ? {24'd0, acks[0]} : 32'hFFFF_FFFF, 32'h10);

    // All-clean pass
    clear_mon();
    init_rf();
    trk = 16'h0000;
`ifndef BACKUP_SELECTIVE_EN
    exp_wa = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    foreach (exp_wa[k]) exp_wd.push_back(32'hDA7A_0000 + exp_wa[k]);
    run_pass(en_c, done_c);
    chk("c_done_cyc", done_c, t6_done);
    check_writes("c");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
